// File: rtl/cache_pkg.sv
// Shared types and address-geometry helpers for the write-back cache.
// Field widths are derived from the line and set counts.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_UPDATE
  } state_e;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int sets, input int line_words);
    return 32 - idx_bits(sets) - off_bits(line_words);
  endfunction

endpackage

// File: rtl/cache_line_xfer_fsm.sv
// Line transfer sequencer: write-back burst, fill burst, array update.
// cnt walks the words of the line and only moves on a transferred word.
module cache_line_xfer_fsm
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  localparam int CNT_W = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss_i,
  input  logic             victim_dirty_i,
  input  logic             wr_gnt_i,
  input  logic             rd_gnt_i,
  input  logic             rd_valid_i,
  output state_e           state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             l2_en_o,
  output logic             l2_wr_en_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and word counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter advance and L2 strobes
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    l2_en_o    = 1'b0;
    l2_wr_en_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (miss_i)
          state_d = victim_dirty_i ? S_WB : S_FILL;
      end
      S_WB: begin
        if (wr_gnt_i) begin
          l2_en_o    = 1'b1;
          l2_wr_en_o = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        l2_en_o = rd_gnt_i;
        if (rd_valid_i) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_UPDATE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign state_o = state_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/cache_param_nway_wb.sv
// N-way set-associative write-back cache with round-robin replacement.
// Arrays, hit detection and victim choice live here; bursts in the FSM.
module cache_param_nway_wb
  import cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 512,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] wrdata_in,
  input  logic        rd_cache,
  input  logic        wr_cache,
  output logic [31:0] rd_data_o,
  output logic        cache_miss,
  input  logic        l2_bus_arbiter_rd_granted,
  input  logic        l2_bus_arbiter_wr_granted,
  output logic [31:0] l2_mem_access_addr,
  output logic [31:0] l2_mem_wr_data,
  input  logic [31:0] l2_mem_rd_data,
  input  logic        l2_mem_rd_valid,
  output logic        l2_mem_en,
  output logic        l2_mem_wr_en
);

  localparam int OFF_BITS = off_bits(LINE_WORDS);
  localparam int IDX_BITS = idx_bits(SETS);
  localparam int TAG_BITS = tag_bits(SETS, LINE_WORDS);
  localparam int WB_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W    = $clog2(LINE_WORDS);

  logic [TAG_BITS-1:0] tag_arr_q  [WAYS][SETS];
  logic [31:0]         data_arr_q [WAYS][SETS][LINE_WORDS];
  logic [31:0]         linebuf_q  [LINE_WORDS];
  logic [SETS-1:0]     valid_q    [WAYS];
  logic [SETS-1:0]     dirty_q    [WAYS];
  logic [WB_W-1:0]     rr_q       [SETS];

  logic [31:0]   addr_q, addr_d;
  logic [WB_W-1:0] victim_q, victim_d;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             fsm_en, fsm_wr_en;

  logic [TAG_BITS-1:0] req_tag, lat_tag;
  logic [IDX_BITS-1:0] req_idx, lat_idx;
  logic [CNT_W-1:0]    req_word;
  logic [WB_W-1:0]     hit_way, vic, rr_nxt;
  logic                hit_any, idle, req, hit;
  logic                wr_hit, miss_start, vic_dirty;
  logic                fill_cap, upd;
  logic                unused_bits;

  assign req_tag  = address[31 -: TAG_BITS];
  assign req_idx  = address[OFF_BITS +: IDX_BITS];
  assign req_word = address[2 +: CNT_W];
  assign lat_tag  = addr_q[31 -: TAG_BITS];
  assign lat_idx  = addr_q[OFF_BITS +: IDX_BITS];

  assign unused_bits = ^{address[1:0], addr_q[OFF_BITS-1:0]};

  // Tag compare across all ways of the indexed set
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && tag_arr_q[w][req_idx] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WB_W'(w);
      end
    end
  end

  assign idle       = (state == S_IDLE);
  assign req        = rd_cache | wr_cache;
  assign hit        = req & hit_any & idle;
  assign wr_hit     = hit & wr_cache;
  assign miss_start = idle & req & ~hit_any;
  assign cache_miss = (req & ~hit) | ~idle;
  assign fill_cap   = (state == S_FILL) & l2_mem_rd_valid;
  assign upd        = (state == S_UPDATE);

  assign rd_data_o = (hit & rd_cache & ~wr_cache)
                   ? data_arr_q[hit_way][req_idx][req_word] : 32'h0;

  // Victim: lowest invalid way, else the set's round-robin pointer
  always_comb begin
    vic = rr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) vic = WB_W'(w);
    end
    vic_dirty = valid_q[vic][req_idx] & dirty_q[vic][req_idx];
    addr_d    = addr_q;
    victim_d  = victim_q;
    if (miss_start) begin
      addr_d   = address;
      victim_d = vic;
    end
    rr_nxt = (int'(rr_q[lat_idx]) == WAYS - 1) ? '0 : rr_q[lat_idx] + 1'b1;
  end

  // L2 address and write data, driven only during bursts
  always_comb begin
    l2_mem_access_addr = 32'h0;
    l2_mem_wr_data     = 32'h0;
    unique case (1'b1)
      state == S_WB: begin
        l2_mem_access_addr = {tag_arr_q[victim_q][lat_idx], lat_idx, cnt, 2'b00};
        l2_mem_wr_data     = data_arr_q[victim_q][lat_idx][cnt];
      end
      state == S_FILL:
        l2_mem_access_addr = {lat_tag, lat_idx, cnt, 2'b00};
      default: ;
    endcase
  end

  assign l2_mem_en    = fsm_en;
  assign l2_mem_wr_en = fsm_wr_en;

  // Control state: latched miss, valid/dirty bits, replacement pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      victim_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      addr_q   <= addr_d;
      victim_q <= victim_d;
      if (upd) begin
        valid_q[victim_q][lat_idx] <= 1'b1;
        dirty_q[victim_q][lat_idx] <= 1'b0;
        rr_q[lat_idx]              <= rr_nxt;
      end
      if (wr_hit) dirty_q[hit_way][req_idx] <= 1'b1;
    end
  end

  // Tag/data storage and the fill line buffer
  always_ff @(posedge clk) begin
    if (fill_cap) linebuf_q[cnt] <= l2_mem_rd_data;
    if (upd) begin
      tag_arr_q[victim_q][lat_idx] <= lat_tag;
      for (int i = 0; i < LINE_WORDS; i++)
        data_arr_q[victim_q][lat_idx][i] <= linebuf_q[i];
    end
    if (wr_hit) data_arr_q[hit_way][req_idx][req_word] <= wrdata_in;
  end

  cache_line_xfer_fsm #(
    .LINE_WORDS (LINE_WORDS)
  ) u_xfer (
    .clk            (clk),
    .rst_n          (rst_n),
    .miss_i         (miss_start),
    .victim_dirty_i (vic_dirty),
    .wr_gnt_i       (l2_bus_arbiter_wr_granted),
    .rd_gnt_i       (l2_bus_arbiter_rd_granted),
    .rd_valid_i     (l2_mem_rd_valid),
    .state_o        (state),
    .cnt_o          (cnt),
    .l2_en_o        (fsm_en),
    .l2_wr_en_o     (fsm_wr_en)
  );

endmodule

// File: tb/tb_cache_param_nway_wb.sv
// Directed bench for the 2-way write-back cache.
// Drives a scripted L2 and checks against hand-computed values.
module tb_cache_param_nway_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address, wrdata_in;
  logic        rd_cache, wr_cache;
  logic [31:0] rd_data_o;
  logic        cache_miss;
  logic        rd_gnt, wr_gnt;
  logic [31:0] l2_addr, l2_wdata, l2_rdata;
  logic        l2_rvalid, l2_en, l2_wr_en;

  int total = 0;
  int bad   = 0;

  cache_param_nway_wb dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .address                   (address),
    .wrdata_in                 (wrdata_in),
    .rd_cache                  (rd_cache),
    .wr_cache                  (wr_cache),
    .rd_data_o                 (rd_data_o),
    .cache_miss                (cache_miss),
    .l2_bus_arbiter_rd_granted (rd_gnt),
    .l2_bus_arbiter_wr_granted (wr_gnt),
    .l2_mem_access_addr        (l2_addr),
    .l2_mem_wr_data            (l2_wdata),
    .l2_mem_rd_data            (l2_rdata),
    .l2_mem_rd_valid           (l2_rvalid),
    .l2_mem_en                 (l2_en),
    .l2_mem_wr_en              (l2_wr_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic l2_idle();
    rd_gnt = 0; wr_gnt = 0; l2_rvalid = 0; l2_rdata = 0;
  endtask

  // Fill 8 words dbase+k at base; optional 3-cycle grant gap after a word
  task automatic do_fill(input logic [31:0] base, input logic [31:0] dbase,
                         input int pause_after);
    for (int k = 0; k < 8; k++) begin
      rd_gnt = 1; l2_rvalid = 1; l2_rdata = dbase + k;
      #1;
      chk("fill_en", {31'b0, l2_en}, 1);
      chk("fill_wr_en", {31'b0, l2_wr_en}, 0);
      chk("fill_addr", l2_addr, base + 4 * k);
      chk("fill_stall", {31'b0, cache_miss}, 1);
      step();
      if (k == pause_after) begin
        for (int p = 0; p < 3; p++) begin
          l2_idle();
          #1;
          chk("pause_en", {31'b0, l2_en}, 0);
          step();
        end
      end
    end
    l2_idle();
    #1;
    chk("update_stall", {31'b0, cache_miss}, 1);
    step();
  endtask

  // Expect an 8-word write-back; one grant gap after word 1
  task automatic do_wb(input logic [31:0] base, input logic [31:0] exp_w [8]);
    for (int k = 0; k < 8; k++) begin
      wr_gnt = 1;
      #1;
      chk("wb_en", {31'b0, l2_en}, 1);
      chk("wb_wr_en", {31'b0, l2_wr_en}, 1);
      chk("wb_addr", l2_addr, base + 4 * k);
      chk("wb_data", l2_wdata, exp_w[k]);
      step();
      if (k == 1) begin
        wr_gnt = 0;
        #1;
        chk("wb_pause_en", {31'b0, l2_en}, 0);
        step();
      end
    end
    wr_gnt = 0;
  endtask

  task automatic rd_hit(input logic [31:0] a, input logic [31:0] exp);
    address = a; rd_cache = 1; wr_cache = 0;
    #1;
    chk("hit_miss", {31'b0, cache_miss}, 0);
    chk("hit_data", rd_data_o, exp);
    chk("hit_no_l2", {31'b0, l2_en}, 0);
  endtask

  logic [31:0] wb_exp [8];

  initial begin
    rst_n = 0; address = 0; wrdata_in = 0; rd_cache = 0; wr_cache = 0;
    l2_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_miss", {31'b0, cache_miss}, 0);
    chk("rst_l2_en", {31'b0, l2_en}, 0);
    chk("rst_l2_addr", l2_addr, 0);
    chk("rst_rd_data", rd_data_o, 0);
    rst_n = 1;
    step();

    // Cold read miss at 0x1000
    address = 32'h1000; rd_cache = 1;
    #1;
    chk("cold_miss", {31'b0, cache_miss}, 1);
    chk("idle_l2_en", {31'b0, l2_en}, 0);
    step();
    do_fill(32'h1000, 32'hA0, -1);
    rd_hit(32'h1000, 32'hA0);
    rd_hit(32'h101C, 32'hA7);

    // Write hit, then simultaneous rd+wr treated as write
    address = 32'h1004; wrdata_in = 32'hDEADBEEF; rd_cache = 0; wr_cache = 1;
    #1;
    chk("wr_hit_miss", {31'b0, cache_miss}, 0);
    chk("wr_hit_no_l2", {31'b0, l2_en}, 0);
    step();
    rd_hit(32'h1004, 32'hDEADBEEF);
    address = 32'h1008; wrdata_in = 32'h12345678; rd_cache = 1; wr_cache = 1;
    #1;
    chk("rdwr_miss", {31'b0, cache_miss}, 0);
    chk("rdwr_rd_data", rd_data_o, 0);
    step();
    rd_hit(32'h1008, 32'h12345678);

    // Second way of the same set
    address = 32'h5000; rd_cache = 1; wr_cache = 0;
    step();
    do_fill(32'h5000, 32'hB0, -1);
    rd_hit(32'h5000, 32'hB0);
    rd_hit(32'h1000, 32'hA0);

    // Conflict miss: dirty way 0 written back, then paused fill
    address = 32'h9000;
    #1;
    chk("conflict_miss", {31'b0, cache_miss}, 1);
    step();
    wb_exp = '{32'hA0, 32'hDEADBEEF, 32'h12345678, 32'hA3,
               32'hA4, 32'hA5, 32'hA6, 32'hA7};
    do_wb(32'h1000, wb_exp);
    do_fill(32'h9000, 32'hC0, 3);
    rd_hit(32'h9000, 32'hC0);
    rd_hit(32'h9014, 32'hC5);
    rd_hit(32'h901C, 32'hC7);
    rd_hit(32'h5004, 32'hB1);

    // Reset during a fill (victim way 1 is clean)
    address = 32'h1000;
    step();
    for (int k = 0; k < 5; k++) begin
      rd_gnt = 1; l2_rvalid = 1; l2_rdata = 32'hD0 + k;
      step();
    end
    rd_gnt = 1; l2_rvalid = 1; l2_rdata = 32'hD5;
    #1;
    chk("pre_rst_addr", l2_addr, 32'h1014);
    rst_n = 0; rd_cache = 0;
    #1;
    chk("arst_l2_en", {31'b0, l2_en}, 0);
    chk("arst_l2_wr_en", {31'b0, l2_wr_en}, 0);
    chk("arst_l2_addr", l2_addr, 0);
    chk("arst_l2_wdata", l2_wdata, 0);
    chk("arst_miss", {31'b0, cache_miss}, 0);
    chk("arst_rd_data", rd_data_o, 0);
    l2_idle();
    step();
    rst_n = 1;
    step();
    address = 32'h9000; rd_cache = 1;
    #1;
    chk("post_rst_miss_9000", {31'b0, cache_miss}, 1);
    address = 32'h1000;
    #1;
    chk("post_rst_miss_1000", {31'b0, cache_miss}, 1);
    chk("post_rst_rd_data", rd_data_o, 0);
    step();
    do_fill(32'h1000, 32'hE0, -1);
    rd_hit(32'h1000, 32'hE0);
    rd_hit(32'h1018, 32'hE6);

    rd_cache = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
